// File: rtl/ps2_key_event_ctrl_if.sv
// Bundle of the scan-code input side and the key-event output side of
// ps2_key_event_ctrl. The slave modport is the controller; the master modport
// is the byte producer plus event consumer driving it.
interface ps2_key_event_ctrl_if;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_err;
    logic       ev_valid;
    logic [9:0] ev_data;
    logic       ev_ready;
    logic       overflow;
    logic [7:0] err_cnt;
    logic       clr;

    modport slave (
        input  rx_valid, rx_data, rx_err, ev_ready, clr,
        output ev_valid, ev_data, overflow, err_cnt
    );

    modport master (
        output rx_valid, rx_data, rx_err, ev_ready, clr,
        input  ev_valid, ev_data, overflow, err_cnt
    );
endinterface

// File: rtl/ps2_key_event_ctrl.sv
// PS/2 key event sequencer: folds E0/F0 prefixes into {ext, release, code}
// events, filters protocol bytes and typematic repeats, and queues events in
// a small FIFO. It also tracks prefix timeouts, framing errors and overflow.
module ps2_key_event_ctrl #(
    parameter int DEPTH         = 8,
    parameter int TIMEOUT       = 50000,
    parameter int FILTER_REPEAT = 1
) (
    input  logic                 clk,
    input  logic                 resetn,
    ps2_key_event_ctrl_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } state_t;

    // Keyboard housekeeping replies that never describe a key action.
    function automatic logic is_proto_byte(input logic [7:0] b);
        return (b == 8'hAA) || (b == 8'hFA) || (b == 8'hEE) ||
               (b == 8'hFE) || (b == 8'h00) || (b == 8'hFF);
    endfunction

    state_t        r_state;
    logic [TW-1:0] r_timer;
    logic [7:0]    r_err_cnt;
    logic          r_overflow;
    logic          r_held_vld;
    logic          r_held_ext;
    logic [7:0]    r_held_code;
    logic [9:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_cnt;
    logic          r_ev_valid;
    logic [9:0]    r_ev_data;

    state_t        w_state_nxt;
    logic [TW-1:0] w_timer_nxt;
    logic          w_err_inc;
    logic          w_ev_gen;
    logic [9:0]    w_ev_data;
    logic          w_is_make;
    logic          w_is_break;
    logic          w_held_match;
    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_wr_ok;
    logic [AW-1:0] w_rd_ptr_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic [9:0]    w_head_nxt;

    // Byte decoder: next prefix state, event generation, timer and error strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_err_inc   = 1'b0;
        w_ev_gen    = 1'b0;
        w_ev_data   = 10'd0;
        if (bus.rx_err) begin
            w_err_inc   = 1'b1;
            w_state_nxt = ST_IDLE;
            w_timer_nxt = '0;
        end else if (bus.rx_valid) begin
            w_timer_nxt = '0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.rx_data == 8'hE0) begin
                        w_state_nxt = ST_EXT;
                    end else if (bus.rx_data == 8'hF0) begin
                        w_state_nxt = ST_BRK;
                    end else if (is_proto_byte(bus.rx_data)) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_ev_gen  = 1'b1;
                        w_ev_data = {1'b0, 1'b0, bus.rx_data};
                    end
                end
                ST_EXT: begin
                    if (bus.rx_data == 8'hF0) begin
                        w_state_nxt = ST_EXT_BRK;
                    end else if (bus.rx_data == 8'hE0) begin
                        w_state_nxt = ST_EXT;
                    end else begin
                        w_ev_gen    = 1'b1;
                        w_ev_data   = {1'b1, 1'b0, bus.rx_data};
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_BRK, ST_EXT_BRK: begin
                    w_state_nxt = ST_IDLE;
                    if ((bus.rx_data == 8'hE0) || (bus.rx_data == 8'hF0)) begin
                        w_err_inc = 1'b1;
                    end else begin
                        w_ev_gen  = 1'b1;
                        w_ev_data = {(r_state == ST_EXT_BRK), 1'b1, bus.rx_data};
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end else if (r_state != ST_IDLE) begin
            if (r_timer == TW'(TIMEOUT - 1)) begin
                w_err_inc   = 1'b1;
                w_state_nxt = ST_IDLE;
                w_timer_nxt = '0;
            end else begin
                w_timer_nxt = r_timer + TW'(1);
            end
        end else begin
            w_timer_nxt = '0;
        end
    end

    // Held-key comparison, repeat filtering and FIFO next-state bookkeeping.
    always_comb begin
        w_is_make    = w_ev_gen & ~w_ev_data[8];
        w_is_break   = w_ev_gen &  w_ev_data[8];
        w_held_match = r_held_vld && (r_held_ext == w_ev_data[9]) &&
                       (r_held_code == w_ev_data[7:0]);
        w_push       = w_ev_gen && !((FILTER_REPEAT != 0) && w_is_make && w_held_match);
        w_pop        = r_ev_valid & bus.ev_ready;
        w_full       = (r_cnt == CW'(DEPTH));
        w_wr_ok      = w_push && (!w_full || w_pop);
        w_rd_ptr_nxt = w_pop ? (r_rd_ptr + AW'(1)) : r_rd_ptr;
        w_cnt_nxt    = r_cnt + CW'(w_wr_ok) - CW'(w_pop);
        if (w_cnt_nxt == CW'(0)) begin
            w_head_nxt = 10'd0;
        end else if (w_wr_ok && (r_wr_ptr == w_rd_ptr_nxt)) begin
            w_head_nxt = w_ev_data;
        end else begin
            w_head_nxt = r_mem[w_rd_ptr_nxt];
        end
    end

    // Prefix FSM, timer, held key and status registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state     <= ST_IDLE;
            r_timer     <= '0;
            r_err_cnt   <= 8'd0;
            r_overflow  <= 1'b0;
            r_held_vld  <= 1'b0;
            r_held_ext  <= 1'b0;
            r_held_code <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
            if (bus.clr) begin
                r_err_cnt <= 8'd0;
            end else if (w_err_inc && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end else begin
                r_err_cnt <= r_err_cnt;
            end
            if (bus.clr) begin
                r_overflow <= 1'b0;
            end else if (w_push && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end else begin
                r_overflow <= r_overflow;
            end
            if (w_is_make) begin
                r_held_vld  <= 1'b1;
                r_held_ext  <= w_ev_data[9];
                r_held_code <= w_ev_data[7:0];
            end else if (w_is_break && w_held_match) begin
                r_held_vld  <= 1'b0;
            end else begin
                r_held_vld  <= r_held_vld;
            end
        end
    end

    // Event storage; pointers are reset separately so stale entries are never seen.
    always_ff @(posedge clk) begin
        if (resetn && w_wr_ok) begin
            r_mem[r_wr_ptr] <= w_ev_data;
        end
    end

    // FIFO pointers, occupancy and registered head-of-queue outputs.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_cnt      <= '0;
            r_ev_valid <= 1'b0;
            r_ev_data  <= 10'd0;
        end else begin
            r_wr_ptr   <= w_wr_ok ? (r_wr_ptr + AW'(1)) : r_wr_ptr;
            r_rd_ptr   <= w_rd_ptr_nxt;
            r_cnt      <= w_cnt_nxt;
            r_ev_valid <= (w_cnt_nxt != CW'(0));
            r_ev_data  <= w_head_nxt;
        end
    end

    assign bus.ev_valid = r_ev_valid;
    assign bus.ev_data  = r_ev_data;
    assign bus.overflow = r_overflow;
    assign bus.err_cnt  = r_err_cnt;
endmodule

// File: doc/ps2_key_event_ctrl.md
Name: ps2_key_event_ctrl

Overview:
- Sequencer behind the PS/2 frame receiver. Consumes validated scan-code bytes and tracks the E0 (extended) and F0 (break) prefixes.
- Produces one make/break key event per key action and buffers events in a FIFO drained by a valid/ready consumer (CPU bus bridge or display logic).
- Filters typematic repeats, protocol bytes, and stale prefixes. Keeps error and overflow status.

Parameters:
- DEPTH, 8, event FIFO entries; power of 2, at least 2.
- TIMEOUT, 50000, max clk cycles allowed between a prefix byte and its following byte.
- FILTER_REPEAT, 1, when 1, repeated make codes of the currently held key are dropped.

Ports:
- clk  in  1  system clock
- resetn  in  1  synchronous active-low reset
- rx_valid  in  1  one-cycle pulse: rx_data holds a received byte that passed start/stop/parity checks
- rx_data  in  8  received byte
- rx_err  in  1  one-cycle pulse: frame failed start/stop/parity checks
- ev_valid  out  1  FIFO non-empty
- ev_data  out  10  head event {ext, release, code[7:0]}
- ev_ready  in  1  consumer pops the head when ev_valid & ev_ready
- overflow  out  1  sticky: an event was dropped because the FIFO was full
- err_cnt  out  8  saturating count of rx_err pulses plus prefix timeouts
- clr  in  1  clears overflow and err_cnt

Behaviour:
- Reset (resetn=0 at posedge clk): FSM=IDLE, FIFO empty, ev_valid=0, ev_data=0, overflow=0, err_cnt=0, held key cleared, timer=0.
- FSM states: IDLE, EXT, BRK, EXT_BRK. All transitions below happen on rx_valid.
- IDLE:
  - E0 -> EXT.
  - F0 -> BRK.
  - AA, FA, EE, FE, 00, FF are dropped; stay in IDLE.
  - Any other code pushes a make event {0,0,code}.
- EXT:
  - F0 -> EXT_BRK.
  - E0 is ignored; stay in EXT.
  - Any other code pushes {1,0,code} -> IDLE.
- BRK: any byte except E0/F0 pushes {0,1,code} -> IDLE. E0 or F0 here is a protocol error: increment err_cnt, go to IDLE.
- EXT_BRK: any byte except E0/F0 pushes {1,1,code} -> IDLE. E0 or F0: same error handling as BRK.
- Held-key register {valid, ext, code}:
  - Set on every make event that is generated.
  - Cleared on a break event whose ext and code match it.
- Repeat filter: with FILTER_REPEAT=1, a make whose {ext, code} equals the valid held key is not pushed. The FSM still returns to IDLE.
- Prefix timeout:
  - The timer resets on every rx_valid and counts only in EXT, BRK, or EXT_BRK.
  - When the timer reaches TIMEOUT-1: go to IDLE, increment err_cnt. No event is pushed.
- rx_err: increment err_cnt, FSM -> IDLE, discard pending prefix. rx_err takes priority over a simultaneous rx_valid, which is ignored.
- err_cnt saturates at 255. clr has priority over an increment in the same cycle; the result is 0.
- Event latency: pushed event is visible at ev_valid/ev_data on the cycle after its rx_valid cycle (registered FIFO, ev_data is the head entry).
- FIFO:
  - Pop when ev_valid & ev_ready.
  - Push when full with no pop in the same cycle: the event is dropped and overflow is set.
  - Push and pop in the same cycle while full: both succeed, count unchanged.
  - Push while empty: ev_valid rises the next cycle.
  - ev_data is held stable while ev_valid=1 and ev_ready=0.
  - Pointers wrap modulo DEPTH; occupancy counter is log2(DEPTH)+1 bits.
- Reset mid-prefix or with a non-empty FIFO: everything returns to reset values; queued events are lost.

Test Plan:
- Bytes 1C, F0, 1C -> events 0x01C, then 0x11C; ev_valid is high the cycle after each rx_valid; held key clear at end.
- Bytes E0, 75, E0, F0, 75 -> events 0x275, then 0x375.
- FILTER_REPEAT=1, bytes 1C, 1C, 1C, F0, 1C -> exactly 2 events: 0x01C, 0x11C.
- ev_ready=0; push DEPTH+1 makes of distinct codes -> first DEPTH events retained in order, overflow=1. Then ev_ready=1 with a simultaneous push -> count stays DEPTH, head advances. clr -> overflow=0.
- E0 followed by TIMEOUT idle cycles, then byte 1C -> err_cnt=1, single event 0x01C. F0, rx_err, 1C -> err_cnt increments, event 0x01C (make, not break).
- AA, FA, EE -> no events. Assert resetn=0 in BRK with 3 queued events -> ev_valid=0, state IDLE. Next byte 2A -> event 0x02A.
